imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: count byte, N big-endian 16-bit words, optional XOR checksum
// (IMEM_LOADER_CHECKSUM_EN); writes land one cycle after the LO byte; no timeout on in_valid gaps.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK = 3'd6
`endif
  } state_t;

  state_t            state_q;
  logic              rdy_q, we_q, hold_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W:0]   words_q;
  logic [7:0]        rem_q, hi_q;
  logic              acc, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    acc       = in_valid && rdy_q;
    last_word = (rem_q == 8'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q ^ in_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      words_q <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q <= COUNT;
            rdy_q   <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        COUNT: begin
          if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_d;
`endif
            if (in_data == 8'd0) begin
              state_q <= ERR;
              rdy_q   <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              rem_q   <= in_data;
              state_q <= HI;
            end
          end
        end
        HI: begin
          if (acc) begin
            hi_q    <= in_data;
            state_q <= LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
          end
        end
        LO: begin
          if (acc) begin
            we_q    <= 1'b1;
            addr_q  <= words_q[ADDR_W-1:0];
            wdata_q <= {hi_q, in_data};
            words_q <= words_q + (ADDR_W+1)'(1);
            rem_q   <= rem_q - 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            state_q <= last_word ? CHK : HI;
`else
            if (last_word) begin
              state_q <= DONE;
              rdy_q   <= 1'b0;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= HI;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (acc) begin
            rdy_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q <= DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = rdy_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; memory writes are checked by a scoreboard monitor.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, imem_we, core_hold, done, error;
  logic [7:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_w;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int GOOD_N = 6;
  localparam bit CSUM   = 1'b1;
`else
  localparam int GOOD_N = 5;
  localparam bit CSUM   = 1'b0;
`endif
  logic [7:0] good_s [6] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
  int         gaps   [6] = '{0, 3, 1, 4, 2, 5};

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp_w) begin
          n_err++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, exp_w[23:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int t;
    in_valid = 1'b0;
    repeat (gap) sync();
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      sync();
      t++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: byte %h not accepted, required acceptance", b);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},   in_ready, 0);
    chk({tag, "_we"},    imem_we, 0);
    chk({tag, "_hold"},  core_hold, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   error, 0);
    chk({tag, "_addr"},  imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  task automatic run_good(input bit bp);
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    for (int i = 0; i < GOOD_N; i++) begin
      send_byte(good_s[i], bp ? gaps[i] : 0);
      if (bp && i == 0) begin
        start = 1'b1;
        sync();
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored_rdy", in_ready, 1);
        chk("start_ignored_hold", core_hold, 1);
        sync();
      end
    end
    @(negedge clk);
    chk("good_done", done, 1);
    chk("good_err", error, 0);
    chk("good_hold", core_hold, 0);
    chk("good_rdy", in_ready, 0);
    chk("good_words", words_loaded, 2);
    chk("good_addr", imem_addr, 8'h01);
    chk("good_wdata", imem_wdata, 16'hABCD);
    sync();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) sync();
    @(negedge clk);
    chk_all_zero("reset");
    sync();
    reset = 1'b1;
    sync();

    // Good load, then status must hold in DONE.
    pulse_start();
    @(negedge clk);
    chk("start_rdy", in_ready, 1);
    chk("start_hold", core_hold, 1);
    sync();
    run_good(1'b0);
    repeat (3) sync();
    @(negedge clk);
    chk("done_hold_words", words_loaded, 2);
    chk("done_hold_done", done, 1);
    sync();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: both writes happen, then ERR.
    pulse_start();
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    for (int i = 0; i < 5; i++) send_byte(good_s[i], 0);
    send_byte(8'h43, 0);
    @(negedge clk);
    chk("badcs_err", error, 1);
    chk("badcs_done", done, 0);
    chk("badcs_hold", core_hold, 1);
    chk("badcs_rdy", in_ready, 0);
    chk("badcs_words", words_loaded, 2);
    sync();
`endif

    // One-word load.
    pulse_start();
    exp_q.push_back({8'h00, 16'h5AA5});
    send_byte(8'h01, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    if (CSUM) send_byte(8'hFE, 0);
    @(negedge clk);
    chk("one_done", done, 1);
    chk("one_we_same_cycle", imem_we, CSUM ? 0 : 1);
    chk("one_words", words_loaded, 1);
    chk("one_rdy", in_ready, 0);
    sync();

    // Zero count goes to ERR; a new start clears it.
    pulse_start();
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("zero_err", error, 1);
    chk("zero_done", done, 0);
    chk("zero_words", words_loaded, 0);
    chk("zero_rdy", in_ready, 0);
    chk("zero_hold", core_hold, 1);
    sync();
    pulse_start();
    @(negedge clk);
    chk("restart_err", error, 0);
    chk("restart_rdy", in_ready, 1);
    chk("restart_words", words_loaded, 0);
    sync();

    // Backpressure gaps with a start pulse in HI (already in COUNT).
    run_good(1'b1);

    // Reset mid-load, coincident with a handshake.
    pulse_start();
    exp_q.push_back({8'h00, 16'h1122});
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    in_valid = 1'b1;
    in_data  = 8'h44;
    reset    = 1'b0;
    sync();
    in_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    repeat (2) sync();
    reset = 1'b1;
    repeat (3) sync();
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 0);
    chk("post_rst_hold", core_hold, 0);
    chk("post_rst_words", words_loaded, 0);
    chk("pending_writes", exp_q.size(), 0);
    sync();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
